ob_table_cnt_seq: RTL and testbench
===================================

Name: ob_table_cnt_seq

Overview:
Multi-beat controller that sums the quantity field of a T-entry table using the team's CSA compressor (ob_table_cnt_csa, op CSA_3_2). Each beat it reads N entries and folds them, with the running sum/carry pair, through one CSA instance of N+2 inputs. A final carry-propagate add produces the result. It sits between the order-book table storage and the level-quantity consumer, which starts a job and collects the result with a valid/ready handshake.

Parameters:
W, 32, quantity word width in bits
N, 4, table entries read per beat (CSA instance width is N+2)
T, 16, table depth in entries; T % N == 0, enforced by elaboration check
IDX_W, $clog2(T), table index width
CNT_W, $clog2(T+1), valid-entry count width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start_vld  in  1  job request
start_rdy  out  1  controller can accept a job (state IDLE)
rd_en  out  1  table read strobe
rd_idx  out  IDX_W  base index of the N-entry read group
rd_data  in  N*W  entry quantities; valid exactly 1 cycle after rd_en
rd_mask  in  N  per-entry valid flags, same timing as rd_data
res_vld  out  1  result available
res_rdy  in  1  consumer accepts result
res_sum  out  W  sum of valid quantities, modulo 2^W
res_cnt  out  CNT_W  number of valid entries
busy  out  1  high in every state except IDLE

Behaviour:
- B = T/N beats per job.
- States: IDLE, RD, DRAIN, ADD, DONE.
- Reset (rst_n=0 at an edge): state IDLE. Read-return pipe flag, beat counter, s/c accumulators, res_sum and res_cnt cleared to 0. Outputs after reset: start_rdy=1, all others 0.
- IDLE: start_rdy=1. On start_vld at cycle t, clear s, c and cnt, go to RD.
- RD (cycles t+1..t+B):
  - rd_en=1 and rd_idx=k*N on beat k=0..B-1.
  - After beat B-1, go to DRAIN.
  - start_vld is ignored in every non-IDLE state.
- Accumulate: on any cycle whose registered rd_en is 1 (t+2..t+B+1):
  - Mask each entry: rd_data lane j is forced to 0 when rd_mask[j]=0.
  - Feed {masked lanes, s, c} to the CSA.
  - Register the CSA sum/carry outputs into s and c.
  - cnt += popcount(rd_mask).
  - rd_data and rd_mask are don't-care on all other cycles.
- DRAIN (t+B+1): absorbs the last return beat, then go to ADD.
- ADD (t+B+2): res_sum <= s + c, truncated to W bits (wrap, no overflow flag); res_cnt <= cnt; go to DONE.
- DONE: res_vld=1 from cycle t+B+3. Start-accept to res_vld latency is B+3 cycles (7 at defaults).
  - res_sum and res_cnt hold stable while res_vld=1 and res_rdy=0.
  - When res_vld and res_rdy are both 1: next cycle IDLE, res_vld=0. res_sum and res_cnt keep their last values until the next ADD.
- Simultaneous events:
  - A start_vld in the result-handshake cycle is not accepted (start_rdy=0). It is accepted the next cycle.
  - Minimum job period is B+4 cycles.
- Reset mid-job: the job is abandoned. A read return arriving the cycle after reset is ignored, because the pipe flag is cleared. The next job's result contains no contribution from the abandoned job.
- Edge case: all rd_mask bits 0 for a whole job gives res_sum=0 and res_cnt=0.

Test Plan:
1. T=16, N=4, W=32. Entry i = i+1, all masks 1. Start at cycle t -> rd_en high t+1..t+4 with rd_idx 0,4,8,12; res_vld at t+7; res_sum=136, res_cnt=16.
2. Same data, rd_mask=4'b0101 every beat (odd entries invalid) -> res_sum=64, res_cnt=8.
3. All entries 0xFFFF_FFFF, all valid -> res_sum=0xFFFF_FFF0 (wrap), res_cnt=16.
4. Hold res_rdy=0 for 5 cycles after res_vld, and pulse start_vld during that window -> res_vld, res_sum and res_cnt stable; start_rdy=0 and no rd_en. After res_rdy=1, IDLE next cycle; start accepted the following cycle.
5. Assert rst_n=0 for one cycle during beat 2 of a job with entries 0x1000 -> next cycle all outputs 0, start_rdy=1. A new job with entries i+1 returns res_sum=136 (no 0x1000 contamination).
6. Drive start_vld in the same cycle as the res_vld & res_rdy handshake -> not accepted that cycle; accepted next cycle. Second job's rd_en starts 2 cycles after the handshake, and its result equals the stand-alone result.

Source files
------------

// File: rtl/ob_table_cnt_seq.sv
// Multi-beat table quantity summer: folds N entries per beat into a carry-save
// sum/carry pair, then resolves it with one carry-propagate add.

module ob_table_cnt_csa #(
    parameter int W = 32,
    parameter int K = 6
) (
    input  logic [K-1:0][W-1:0] ops,
    output logic [W-1:0]        sum,
    output logic [W-1:0]        carry
);

    logic [W-1:0] t_sum;

    // Chain of 3:2 compressors; the carry is pre-shifted so sum + carry equals the total mod 2^W.
    always_comb begin
        sum   = ops[0];
        carry = ops[1];
        t_sum = '0;
        for (int i = 2; i < K; i++) begin
            t_sum = sum ^ carry ^ ops[i];
            carry = ((sum & carry) | (sum & ops[i]) | (carry & ops[i])) << 1;
            sum   = t_sum;
        end
    end

endmodule

module ob_table_cnt_seq #(
    parameter int W     = 32,
    parameter int N     = 4,
    parameter int T     = 16,
    parameter int IDX_W = $clog2(T),
    parameter int CNT_W = $clog2(T + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_vld,
    output logic             start_rdy,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [N*W-1:0]   rd_data,
    input  logic [N-1:0]     rd_mask,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [W-1:0]     res_sum,
    output logic [CNT_W-1:0] res_cnt,
    output logic             busy
);

    generate
        if (T % N != 0) begin : g_bad_depth
            $error("ob_table_cnt_seq: T must be a multiple of N");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(T - N);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(N);

    typedef enum logic [2:0] {IDLE, RD, DRAIN, ADD, DONE} state_t;

    state_t               state, next_state;
    logic [IDX_W-1:0]     beat_idx;
    logic                 ret_vld;
    logic [W-1:0]         s_acc, c_acc;
    logic [CNT_W-1:0]     cnt;
    logic [N+1:0][W-1:0]  csa_ops;
    logic [W-1:0]         csa_sum, csa_carry;
    logic [CNT_W-1:0]     pop;

    assign start_rdy = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rd_en     = (state == RD);
    assign rd_idx    = beat_idx;
    assign res_vld   = (state == DONE);

    // Invalid lanes are zeroed so they contribute nothing to the compressor.
    always_comb begin
        csa_ops = '0;
        pop     = '0;
        for (int j = 0; j < N; j++) begin
            csa_ops[j] = rd_data[j*W +: W] & {W{rd_mask[j]}};
            pop        = pop + CNT_W'(rd_mask[j]);
        end
        csa_ops[N]   = s_acc;
        csa_ops[N+1] = c_acc;
    end

    ob_table_cnt_csa #(.W(W), .K(N + 2)) u_csa (
        .ops   (csa_ops),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_vld) next_state = RD;
            RD:      if (beat_idx == LAST_IDX) next_state = DRAIN;
            DRAIN:   next_state = ADD;
            ADD:     next_state = DONE;
            DONE:    if (res_rdy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Clearing ret_vld on reset drops any read return still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_idx <= '0;
            ret_vld  <= 1'b0;
            s_acc    <= '0;
            c_acc    <= '0;
            cnt      <= '0;
            res_sum  <= '0;
            res_cnt  <= '0;
        end else begin
            state   <= next_state;
            ret_vld <= rd_en;
            if (state == IDLE && start_vld) begin
                beat_idx <= '0;
                s_acc    <= '0;
                c_acc    <= '0;
                cnt      <= '0;
            end
            if (state == RD) begin
                beat_idx <= beat_idx + STEP;
            end
            if (ret_vld) begin
                s_acc <= csa_sum;
                c_acc <= csa_carry;
                cnt   <= cnt + pop;
            end
            if (state == ADD) begin
                res_sum <= s_acc + c_acc;
                res_cnt <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_ob_table_cnt_seq.sv
// Directed bench for ob_table_cnt_seq with a one-cycle-latency table responder.

module tb_ob_table_cnt_seq;

    localparam int W = 32;
    localparam int N = 4;
    localparam int T = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_vld;
    logic          start_rdy;
    logic          rd_en;
    logic [3:0]    rd_idx;
    logic [N*W-1:0] rd_data;
    logic [N-1:0]  rd_mask;
    logic          res_vld;
    logic          res_rdy;
    logic [W-1:0]  res_sum;
    logic [4:0]    res_cnt;
    logic          busy;

    logic [W-1:0]  tbl [T];
    logic [N-1:0]  mask_pat;
    logic          tb_ret_vld;
    logic [3:0]    tb_ret_idx;

    int passed = 0;
    int total  = 0;

    ob_table_cnt_seq #(.W(W), .N(N), .T(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_vld (start_vld),
        .start_rdy (start_rdy),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_mask   (rd_mask),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .res_sum   (res_sum),
        .res_cnt   (res_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tb_ret_vld <= rd_en;
        tb_ret_idx <= rd_idx;
    end

    // Off-return cycles carry garbage so a stray accumulate shows up in the sum.
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < N; j++) begin
            if (tb_ret_vld) rd_data[j*W +: W] = tbl[(int'(tb_ret_idx) + j) % T];
            else            rd_data[j*W +: W] = 32'hDEAD_BEEF;
        end
        rd_mask = tb_ret_vld ? mask_pat : 4'hF;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic fill_table(input int mode, input logic [W-1:0] val);
        for (int i = 0; i < T; i++) tbl[i] = (mode == 0) ? W'(i + 1) : val;
    endtask

    // Starts at cycle t+1 of a job; leaves the bench in the first DONE cycle.
    task automatic follow_job(input logic [W-1:0] exp_sum, input logic [4:0] exp_cnt, input string tag);
        int lat;
        lat = 1;
        checkOutput({tag, "_busy"}, busy, 1'b1);
        for (int k = 0; k < T / N; k++) begin
            checkOutput({tag, "_rd_en"}, rd_en, 1'b1);
            checkOutput({tag, "_rd_idx"}, rd_idx, k * N);
            tick();
            lat++;
        end
        while (!res_vld && lat < 30) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 7);
        checkOutput({tag, "_sum"}, res_sum, exp_sum);
        checkOutput({tag, "_cnt"}, res_cnt, exp_cnt);
    endtask

    task automatic applyStimulus(input logic [W-1:0] exp_sum, input logic [4:0] exp_cnt, input string tag);
        checkOutput({tag, "_start_rdy"}, start_rdy, 1'b1);
        start_vld = 1'b1;
        tick();
        start_vld = 1'b0;
        follow_job(exp_sum, exp_cnt, tag);
    endtask

    task automatic finish_job(input string tag);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        checkOutput({tag, "_vld_drop"}, res_vld, 1'b0);
        checkOutput({tag, "_idle"}, start_rdy, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start_vld = 1'b0;
        res_rdy   = 1'b0;
        mask_pat  = 4'hF;
        fill_table(0, '0);
        tick();
        tick();
        checkOutput("rst_start_rdy", start_rdy, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rd_en", rd_en, 1'b0);
        checkOutput("rst_res_vld", res_vld, 1'b0);
        checkOutput("rst_res_sum", res_sum, 32'h0);
        checkOutput("rst_res_cnt", res_cnt, 5'd0);
        rst_n = 1'b1;
        tick();

        // Entries 1..16, all valid.
        applyStimulus(32'd136, 5'd16, "full");
        finish_job("full");

        // Lanes 1 and 3 invalid: 1+3+...+15.
        mask_pat = 4'b0101;
        applyStimulus(32'd64, 5'd8, "masked");
        finish_job("masked");

        // All-ones entries wrap to -16.
        mask_pat = 4'hF;
        fill_table(1, 32'hFFFF_FFFF);
        applyStimulus(32'hFFFF_FFF0, 5'd16, "wrap");
        finish_job("wrap");

        // No valid entries at all.
        mask_pat = 4'h0;
        applyStimulus(32'h0, 5'd0, "empty");
        finish_job("empty");

        // Backpressure with a start pulse during the hold window.
        mask_pat = 4'hF;
        fill_table(0, '0);
        applyStimulus(32'd136, 5'd16, "hold");
        for (int i = 0; i < 5; i++) begin
            start_vld = (i == 2);
            tick();
            checkOutput("hold_vld", res_vld, 1'b1);
            checkOutput("hold_sum", res_sum, 32'd136);
            checkOutput("hold_cnt", res_cnt, 5'd16);
            checkOutput("hold_start_rdy", start_rdy, 1'b0);
            checkOutput("hold_rd_en", rd_en, 1'b0);
        end
        start_vld = 1'b0;
        finish_job("hold");
        checkOutput("hold_sum_keep", res_sum, 32'd136);
        tick();

        // Reset during beat 2 of a 0x1000 job.
        fill_table(1, 32'h0000_1000);
        start_vld = 1'b1;
        tick();
        start_vld = 1'b0;
        tick();
        tick();
        checkOutput("abort_beat2_idx", rd_idx, 4'd8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_start_rdy", start_rdy, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_rd_en", rd_en, 1'b0);
        checkOutput("abort_res_vld", res_vld, 1'b0);
        checkOutput("abort_res_sum", res_sum, 32'h0);
        checkOutput("abort_res_cnt", res_cnt, 5'd0);
        tick();
        fill_table(0, '0);
        applyStimulus(32'd136, 5'd16, "post_abort");

        // Start held through the handshake cycle: taken one cycle later.
        start_vld = 1'b1;
        res_rdy   = 1'b1;
        tick();
        res_rdy = 1'b0;
        checkOutput("b2b_vld_drop", res_vld, 1'b0);
        checkOutput("b2b_start_rdy", start_rdy, 1'b1);
        checkOutput("b2b_no_rd", rd_en, 1'b0);
        tick();
        start_vld = 1'b0;
        follow_job(32'd136, 5'd16, "b2b");
        finish_job("b2b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
